// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-controller backing store: port ids and the
// read-return tag carried down the fixed-latency read pipeline.
package mem_ctrl_pkg;

  localparam int MAX_RD_LATENCY = 8;
  localparam int DATA_W         = 32;

  typedef enum logic {
    PORT_DATA  = 1'b0,
    PORT_FETCH = 1'b1
  } port_e;

  typedef struct packed {
    logic              valid;
    port_e             port;
    logic [DATA_W-1:0] data;
  } rd_tag_t;

endpackage

// File: rtl/mem_ctrl_rr_arb.sv
// Two-requester round-robin arbiter. The pointer only advances on a contested
// cycle, handing the next contest to the port that just lost.
module mem_ctrl_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt   = (ptr_q == PORT_DATA) ? 2'b01 : 2'b10;
        ptr_d = (ptr_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PORT_DATA;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_ctrl_backing_mem.sv
// Single-ported backing array shared by the data and fetch ports: one access
// per cycle, reads returned through a fixed-latency tag pipeline.
module mem_ctrl_backing_mem
  import mem_ctrl_pkg::*;
#(
  parameter  int MEM_DEPTH  = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int RD_LATENCY = 2,
  localparam int AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         mem_raddr,
  input  logic                  mem_ren,
  output logic                  mem_rready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_valid,
  input  logic [AW-1:0]         mem_waddr,
  input  logic                  mem_wen,
  output logic                  mem_wready,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [AW-1:0]         fetch_mem_raddr,
  input  logic                  fetch_mem_ren,
  output logic                  fetch_mem_rready,
  output logic [DATA_WIDTH-1:0] fetch_mem_rdata,
  output logic                  fetch_mem_rdata_valid,
  input  logic [AW-1:0]         fetch_mem_waddr,
  input  logic                  fetch_mem_wen,
  output logic                  fetch_mem_wready,
  input  logic [DATA_WIDTH-1:0] fetch_mem_wdata
);

  localparam int          LAT       = (RD_LATENCY < 1) ? 1 :
                                      (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  logic [1:0] req, gnt;
  assign req = {fetch_mem_wen | fetch_mem_ren, mem_wen | mem_ren};

  mem_ctrl_rr_arb u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));

  // Within the granted port a write wins; its read waits for a later grant.
  assign mem_wready       = gnt[0] & mem_wen;
  assign mem_rready       = gnt[0] & ~mem_wen & mem_ren;
  assign fetch_mem_wready = gnt[1] & fetch_mem_wen;
  assign fetch_mem_rready = gnt[1] & ~fetch_mem_wen & fetch_mem_ren;

  logic                  we, re;
  logic [AW-1:0]         wa, ra;
  logic [DATA_WIDTH-1:0] wd;
  port_e                 rport;

  always_comb begin
    we    = mem_wready | fetch_mem_wready;
    re    = mem_rready | fetch_mem_rready;
    wa    = gnt[1] ? fetch_mem_waddr : mem_waddr;
    wd    = gnt[1] ? fetch_mem_wdata : mem_wdata;
    ra    = gnt[1] ? fetch_mem_raddr : mem_raddr;
    rport = gnt[1] ? PORT_FETCH : PORT_DATA;
  end

  // Storage is deliberately not reset so contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we && in_range(wa)) mem_q[wa] <= wd;
  end

  rd_tag_t acc_tag, ret;
  rd_tag_t tag_q [LAT];

  always_comb begin
    acc_tag       = '0;
    acc_tag.valid = re;
    acc_tag.port  = rport;
    if (re && in_range(ra)) acc_tag.data = DATA_W'(mem_q[ra]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= acc_tag;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret = tag_q[LAT-1];

  logic [DATA_WIDTH-1:0] mem_hold_q, fetch_hold_q;

  assign mem_rdata_valid       = ret.valid && (ret.port == PORT_DATA);
  assign fetch_mem_rdata_valid = ret.valid && (ret.port == PORT_FETCH);
  assign mem_rdata             = mem_rdata_valid ? DATA_WIDTH'(ret.data) : mem_hold_q;
  assign fetch_mem_rdata       = fetch_mem_rdata_valid ? DATA_WIDTH'(ret.data) : fetch_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_hold_q   <= '0;
      fetch_hold_q <= '0;
    end else begin
      if (mem_rdata_valid)       mem_hold_q   <= DATA_WIDTH'(ret.data);
      if (fetch_mem_rdata_valid) fetch_hold_q <= DATA_WIDTH'(ret.data);
    end
  end

endmodule
